mmul_loader: RTL and testbench

//   Upstream feeder for mmul: accepts a serial element stream (valid/ready), packs operands A then B

---
 rtl/mmul_pkg.sv | 28 ++
 rtl/mmul_mat_pack.sv | 24 ++
 rtl/mmul_loader.sv | 145 ++++++++++++++
 tb/tb_mmul_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_pkg.sv
// Shared types and sizing for the mmul datapath: FSM state encoding, default
// matrix dimensions and the element-counter width helper.
package mmul_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int MMUL_M     = 3;
  localparam int MMUL_N     = 3;
  localparam int MMUL_K     = 3;
  localparam int MMUL_L     = 3;
  localparam int MMUL_WIDTH = 8;

  localparam int A_ELEMS = MMUL_M * MMUL_N;
  localparam int B_ELEMS = MMUL_K * MMUL_L;

  // Wide enough to hold the largest element count of either operand.
  function automatic int cnt_bits(input int a_elems, input int b_elems);
    return $clog2(((a_elems > b_elems) ? a_elems : b_elems) + 1);
  endfunction

  localparam int CNT_W = cnt_bits(A_ELEMS, B_ELEMS);

endpackage

// File: rtl/mmul_mat_pack.sv
// Packed matrix register: writes one element per cycle at a given row-major
// index into a flat bus; contents are held until overwritten or reset.
module mmul_mat_pack #(
  parameter int ELEMS = 9,
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [ELEMS*WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (wr_en) begin
      data[wr_idx*WIDTH +: WIDTH] <= wr_data;
    end
  end

endmodule

// File: rtl/mmul_loader.sv
// Stream front end for mmul: packs a serial row-major element stream into A
// then B, runs the enable/done handshake and re-arms for the next batch.
module mmul_loader
  import mmul_pkg::*;
#(
  parameter int M     = MMUL_M,
  parameter int N     = MMUL_N,
  parameter int K     = MMUL_K,
  parameter int L     = MMUL_L,
  parameter int WIDTH = MMUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [M*N*WIDTH-1:0] mat_a,
  output logic [K*L*WIDTH-1:0] mat_b,
  output logic                 mmul_enable,
  input  logic                 mmul_done,
  input  logic                 mmul_invalid,
  output logic                 batch_done,
  output logic                 error,
  output logic                 busy,
  output state_t               fsm_state
);

  localparam int A_LEN = M * N;
  localparam int B_LEN = K * L;
  localparam int CW    = cnt_bits(A_LEN, B_LEN);
  localparam logic [CW-1:0] A_LAST = CW'(A_LEN - 1);
  localparam logic [CW-1:0] B_LAST = CW'(B_LEN - 1);

  // Stream handshake: an element moves on any rising edge where
  // in_valid && in_ready; in_ready never depends on in_valid.
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            ready_en;
  logic            xfer;
  logic            wr_a, wr_b;
  logic            done_set, err_set;

  // ready_en keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD_A;
      cnt        <= '0;
      ready_en   <= 1'b0;
      batch_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ready_en   <= 1'b1;
      batch_done <= done_set;
      error      <= err_set;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wr_a     = 1'b0;
    wr_b     = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    in_ready = ready_en && !flush && ((state == LOAD_A) || (state == LOAD_B));
    xfer     = in_valid && in_ready;

    case (state)
      LOAD_A: begin
        if (xfer) begin
          wr_a = 1'b1;
          if (cnt == A_LAST) begin
            cnt_n   = '0;
            state_n = LOAD_B;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          wr_b = 1'b1;
          if (cnt == B_LAST) begin
            cnt_n   = '0;
            state_n = RUN;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      RUN: begin
        // An operand error outranks a simultaneous done.
        if (mmul_invalid) begin
          err_set = 1'b1;
          state_n = RELEASE;
        end else if (mmul_done) begin
          done_set = 1'b1;
          state_n  = RELEASE;
        end
      end
      RELEASE: begin
        state_n = LOAD_A;
        cnt_n   = '0;
      end
      default: begin
        state_n = LOAD_A;
        cnt_n   = '0;
      end
    endcase

    if (flush) begin
      state_n  = LOAD_A;
      cnt_n    = '0;
      done_set = 1'b0;
      err_set  = 1'b0;
    end
  end

  // Decoded from the state register so an async reset drops enable at once.
  assign mmul_enable = (state == RUN);
  assign busy        = !((state == LOAD_A) && (cnt == '0));
  assign fsm_state   = state;

  mmul_mat_pack #(.ELEMS(A_LEN), .WIDTH(WIDTH), .IDX_W(CW)) u_pack_a (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_a),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .data    (mat_a)
  );

  mmul_mat_pack #(.ELEMS(B_LEN), .WIDTH(WIDTH), .IDX_W(CW)) u_pack_b (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_b),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .data    (mat_b)
  );

endmodule

// File: tb/tb_mmul_loader.sv
// Directed bench for mmul_loader: stream loads, done/invalid handshakes,
// flush abort and asynchronous reset in RUN.
module tb_mmul_loader;
  import mmul_pkg::*;

  localparam int BOUND = 400;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [71:0] mat_a;
  logic [71:0] mat_b;
  logic        mmul_enable;
  logic        mmul_done;
  logic        mmul_invalid;
  logic        batch_done;
  logic        error;
  logic        busy;
  state_t      fsm_state;

  int n_cmp;
  int n_bad;
  int edges;
  logic [7:0] stim [18];

  // Hand-packed buses: element idx k sits at [k*8 +: 8].
  localparam logic [71:0] EXP_A1 = 72'h02_08_03_05_00_01_03_02_01;
  localparam logic [71:0] EXP_B1 = 72'h08_00_02_01_06_05_03_00_00;
  localparam logic [71:0] EXP_A2 = 72'h19_18_17_16_15_14_13_12_11;
  localparam logic [71:0] EXP_B2 = 72'h29_28_27_26_25_24_23_22_21;
  localparam logic [71:0] EXP_A3 = 72'h39_38_37_36_35_34_33_32_31;
  localparam logic [71:0] EXP_B3 = 72'h49_48_47_46_45_44_43_42_41;

  mmul_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .mat_a        (mat_a),
    .mat_b        (mat_b),
    .mmul_enable  (mmul_enable),
    .mmul_done    (mmul_done),
    .mmul_invalid (mmul_invalid),
    .batch_done   (batch_done),
    .error        (error),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_stim(input logic [71:0] a, input logic [71:0] b);
    for (int k = 0; k < 9; k++) begin
      stim[k]     = a[k*8 +: 8];
      stim[k + 9] = b[k*8 +: 8];
    end
  endtask

  // Drives stim[first..first+n-1] from a negedge; gap=1 gives ~50% idle cycles.
  // Returns at the negedge after the last transfer with the edge count.
  task automatic feed(input int first, input int n, input bit gap, output int n_edges);
    int i;
    logic take;
    i = 0;
    n_edges = 0;
    while (i < n && n_edges < BOUND) begin
      in_valid = gap ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = stim[first + i];
      #1;
      take = in_valid && in_ready;
      @(posedge clk);
      n_edges++;
      if (take) i++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("feed_count", 128'(i), 128'(n));
  endtask

  // Holds RUN for run_cycles negedges, then answers with done/invalid.
  task automatic finish_run(input int run_cycles, input logic d, input logic inv);
    check("run_enable", 128'(mmul_enable), 128'(1));
    check("run_ready", 128'(in_ready), 128'(0));
    check("run_busy", 128'(busy), 128'(1));
    repeat (run_cycles - 1) @(negedge clk);
    check("run_enable_held", 128'(mmul_enable), 128'(1));
    mmul_done    = d;
    mmul_invalid = inv;
    @(negedge clk);
    mmul_done    = 1'b0;
    mmul_invalid = 1'b0;
    check("rel_state", 128'(fsm_state), 128'(RELEASE));
    check("rel_batch_done", 128'(batch_done), 128'(d && !inv));
    check("rel_error", 128'(error), 128'(inv));
    check("rel_enable", 128'(mmul_enable), 128'(0));
    check("rel_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    check("idle_state", 128'(fsm_state), 128'(LOAD_A));
    check("idle_pulses", 128'({batch_done, error}), 128'(0));
    check("idle_ready", 128'(in_ready), 128'(1));
    check("idle_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b0;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    flush        = 1'b0;
    mmul_done    = 1'b0;
    mmul_invalid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", 128'(fsm_state), 128'(LOAD_A));
    check("rst_mats", {56'd0, mat_a}, 128'(0));
    check("rst_mat_b", {56'd0, mat_b}, 128'(0));
    check("rst_outs", 128'({in_ready, mmul_enable, batch_done, error, busy}), 128'(0));
    reset = 1'b1;
    #1;
    check("rel_ready_low", 128'(in_ready), 128'(0));

    // 1: back-to-back load, enable on the 19th edge after release
    set_stim(EXP_A1, EXP_B1);
    feed(0, 18, 1'b0, edges);
    check("s1_edges", 128'(edges), 128'(19));
    check("s1_a00", 128'(mat_a[7:0]), 128'(1));
    check("s1_a22", 128'(mat_a[71:64]), 128'(2));
    check("s1_b22", 128'(mat_b[71:64]), 128'(8));
    check("s1_mat_a", {56'd0, mat_a}, {56'd0, EXP_A1});
    check("s1_mat_b", {56'd0, mat_b}, {56'd0, EXP_B1});
    check("s1_state", 128'(fsm_state), 128'(RUN));

    // 2: done 10 cycles after enable, then a second batch
    finish_run(10, 1'b1, 1'b0);
    check("s2_hold_a", {56'd0, mat_a}, {56'd0, EXP_A1});
    check("s2_hold_b", {56'd0, mat_b}, {56'd0, EXP_B1});
    set_stim(EXP_A2, EXP_B2);
    feed(0, 18, 1'b0, edges);
    check("s2_edges", 128'(edges), 128'(18));
    check("s2_mat_a", {56'd0, mat_a}, {56'd0, EXP_A2});
    check("s2_mat_b", {56'd0, mat_b}, {56'd0, EXP_B2});
    finish_run(3, 1'b1, 1'b0);

    // 3: random valid gaps give the same buses as scenario 1
    set_stim(EXP_A1, EXP_B1);
    feed(0, 18, 1'b1, edges);
    check("s3_mat_a", {56'd0, mat_a}, {56'd0, EXP_A1});
    check("s3_mat_b", {56'd0, mat_b}, {56'd0, EXP_B1});
    finish_run(2, 1'b1, 1'b0);

    // 4: flush alongside a valid element after 5 A elements
    set_stim(EXP_A2, EXP_B2);
    feed(0, 5, 1'b0, edges);
    check("s4_busy_partial", 128'(busy), 128'(1));
    in_valid = 1'b1;
    in_data  = 8'hAA;
    flush    = 1'b1;
    #1;
    check("s4_ready_forced", 128'(in_ready), 128'(0));
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("s4_state", 128'(fsm_state), 128'(LOAD_A));
    check("s4_busy", 128'(busy), 128'(0));
    check("s4_pulses", 128'({batch_done, error, mmul_enable}), 128'(0));
    set_stim(EXP_A3, EXP_B3);
    feed(0, 18, 1'b0, edges);
    check("s4_edges", 128'(edges), 128'(18));
    check("s4_mat_a", {56'd0, mat_a}, {56'd0, EXP_A3});
    check("s4_mat_b", {56'd0, mat_b}, {56'd0, EXP_B3});
    finish_run(2, 1'b1, 1'b0);

    // 5: invalid and done together -> error only
    set_stim(EXP_A1, EXP_B1);
    feed(0, 18, 1'b0, edges);
    finish_run(4, 1'b1, 1'b1);

    // 6: asynchronous reset while in RUN
    set_stim(EXP_A2, EXP_B2);
    feed(0, 18, 1'b0, edges);
    check("s6_run", 128'(mmul_enable), 128'(1));
    #2;
    reset = 1'b0;
    #1;
    check("s6_enable_async", 128'(mmul_enable), 128'(0));
    check("s6_state", 128'(fsm_state), 128'(LOAD_A));
    check("s6_mat_a", {56'd0, mat_a}, 128'(0));
    check("s6_mat_b", {56'd0, mat_b}, 128'(0));
    check("s6_outs", 128'({in_ready, batch_done, error, busy}), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    set_stim(EXP_A1, EXP_B1);
    feed(0, 18, 1'b0, edges);
    check("s6_edges", 128'(edges), 128'(19));
    check("s6_mat_a_resume", {56'd0, mat_a}, {56'd0, EXP_A1});
    check("s6_mat_b_resume", {56'd0, mat_b}, {56'd0, EXP_B1});
    finish_run(2, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
